// File: rtl/neuron_sgd_update.sv
// SGD weight/bias update stage for a single sigmoid neuron.
// Owns the neuron's weight and bias registers; each pass updates one element per cycle.
module neuron_sgd_update #(
  parameter int unsigned N    = 2,
  parameter int unsigned BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_w,
  input  logic [N*BITS-1:0]   w_init,
  input  logic [BITS-1:0]     b_init,
  input  logic                start,
  input  logic [BITS-1:0]     dZ,
  input  logic [N*BITS-1:0]   x,
  input  logic [BITS-1:0]     lr,
  output logic                busy,
  output logic                done,
  output logic [N*BITS-1:0]   w,
  output logic [BITS-1:0]     b
);

  localparam int unsigned IdxW = $clog2(N + 1);
  localparam int unsigned Frac = 8;
  localparam int unsigned PW   = 2 * BITS;

  typedef enum logic [1:0] {StIdle, StLoad, StUpd, StDone} state_e;

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [BITS-1:0]            dz_q, dz_d;
  logic [BITS-1:0]            lr_q, lr_d;
  logic [N-1:0][BITS-1:0]     x_q, x_d;
  logic [N-1:0][BITS-1:0]     w_q, w_d;
  logic [BITS-1:0]            b_q, b_d;

  // Clip a wide signed value into the BITS-wide two's-complement range.
  function automatic logic [BITS-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] lo;
    hi = '0;
    hi[BITS-2:0] = '1;
    lo = '1;
    lo[BITS-2:0] = '0;
    if (v > hi) begin
      return hi[BITS-1:0];
    end else if (v < lo) begin
      return lo[BITS-1:0];
    end else begin
      return v[BITS-1:0];
    end
  endfunction

  logic                   is_bias;
  logic [BITS-1:0]        x_sel;
  logic [BITS-1:0]        old_val;
  logic signed [PW-1:0]   prod_g;
  logic signed [PW-1:0]   prod_d;
  logic [BITS-1:0]        g;
  logic [BITS-1:0]        delta;
  logic signed [BITS:0]   diff;
  logic [BITS-1:0]        new_val;

  always_comb begin
    x_sel   = '0;
    old_val = b_q;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IdxW'(i)) begin
        x_sel   = x_q[i];
        old_val = w_q[i];
      end
    end
    is_bias = (idx_q == IdxW'(N));
    prod_g  = $signed(dz_q) * $signed(x_sel);
    g       = is_bias ? dz_q : sat(prod_g >>> Frac);
    prod_d  = $signed(lr_q) * $signed(g);
    delta   = sat(prod_d >>> Frac);
    diff    = $signed({old_val[BITS-1], old_val}) - $signed({delta[BITS-1], delta});
    new_val = sat({{(PW-BITS-1){diff[BITS]}}, diff});
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dz_d    = dz_q;
    lr_d    = lr_q;
    x_d     = x_q;
    w_d     = w_q;
    b_d     = b_q;
    case (state_q)
      StIdle: begin
        // load_w has priority; a coincident start is dropped.
        if (load_w) begin
          state_d = StLoad;
        end else if (start) begin
          state_d = StUpd;
          dz_d    = dZ;
          lr_d    = lr;
          x_d     = x;
          idx_d   = '0;
        end
      end
      StLoad: begin
        w_d     = w_init;
        b_d     = b_init;
        state_d = StIdle;
      end
      StUpd: begin
        if (is_bias) begin
          b_d     = new_val;
          state_d = StDone;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (idx_q == IdxW'(i)) w_d[i] = new_val;
          end
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      dz_q    <= '0;
      lr_q    <= '0;
      x_q     <= '0;
      w_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dz_q    <= dz_d;
      lr_q    <= lr_d;
      x_q     <= x_d;
      w_q     <= w_d;
      b_q     <= b_d;
    end
  end

  assign w    = w_q;
  assign b    = b_q;
  assign busy = (state_q == StUpd);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_neuron_sgd_update.sv
// Scoreboard bench for neuron_sgd_update (N=2, Q8.8): directed passes with hand-computed results.
module tb_neuron_sgd_update;

  localparam int unsigned N    = 2;
  localparam int unsigned BITS = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                load_w;
  logic [N*BITS-1:0]   w_init;
  logic [BITS-1:0]     b_init;
  logic                start;
  logic [BITS-1:0]     dZ;
  logic [N*BITS-1:0]   x;
  logic [BITS-1:0]     lr;
  logic                busy;
  logic                done;
  logic [N*BITS-1:0]   w;
  logic [BITS-1:0]     b;

  neuron_sgd_update #(.N(N), .BITS(BITS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_w (load_w),
    .w_init (w_init),
    .b_init (b_init),
    .start  (start),
    .dZ     (dZ),
    .x      (x),
    .lr     (lr),
    .busy   (busy),
    .done   (done),
    .w      (w),
    .b      (b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] b;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    int   bcnt;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0;
      end else begin
        if (busy) bcnt++;
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            check("w0", 32'(w[15:0]), 32'(e.w0));
            check("w1", 32'(w[31:16]), 32'(e.w1));
            check("b", 32'(b), 32'(e.b));
            check("done_cycle", 32'(cyc), 32'(e.done_cyc));
            check("busy_cycles", 32'(bcnt), 32'(N + 1));
          end
          bcnt = 0;
        end
      end
    end
  end

  task automatic do_load(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] b0);
    @(negedge clk);
    w_init = {w1, w0};
    b_init = b0;
    load_w = 1'b1;
    @(negedge clk);
    load_w = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] dz_v, input logic [15:0] x0, input logic [15:0] x1,
                          input logic [15:0] lr_v, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] eb);
    @(negedge clk);
    dZ    = dz_v;
    x     = {x1, x0};
    lr    = lr_v;
    start = 1'b1;
    sb.push_back('{e0, e1, eb, cyc + N + 2});
    @(negedge clk);
    start = 1'b0;
    // Sampled copies must be used; scramble the live inputs.
    dZ    = 16'($urandom);
    x     = 32'($urandom);
    lr    = 16'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    load_w = 1'b0;
    start  = 1'b0;
    w_init = '0;
    b_init = '0;
    dZ     = '0;
    x      = '0;
    lr     = '0;
    repeat (2) @(negedge clk);
    check("rst_w", w, 32'h0);
    check("rst_b", 32'(b), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_w", w, 32'h0);
    check("idle_b", 32'(b), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    // Basic step, with extra start/load_w strobes while busy.
    do_load(16'h0300, 16'h0100, 16'h0100);
    check("load_w", w, 32'h0100_0300);
    check("load_b", 32'(b), 32'h0100);
    do_start(16'h0100, 16'h0200, 16'h0080, 16'h0080, 16'h0200, 16'h00C0, 16'h0080);
    start  = 1'b1;
    load_w = 1'b1;
    w_init = 32'hDEAD_BEEF;
    @(negedge clk);
    start  = 1'b0;
    load_w = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // Negative values and truncation toward -inf.
    do_load(16'h0000, 16'h1234, 16'h0000);
    do_start(16'hFF00, 16'h0001, 16'h0000, 16'h0100, 16'h0001, 16'h1234, 16'h0100);
    wait_idle();

    // Saturation of g and of the updated weights.
    do_load(16'h8010, 16'h7FF0, 16'h0000);
    do_start(16'h7F00, 16'h7F00, 16'h8100, 16'h0100, 16'h8000, 16'h7FFF, 16'h8100);
    wait_idle();

    // lr=0 and dZ=0 still run full length with no change.
    do_start(16'h7F00, 16'h1234, 16'h4321, 16'h0000, 16'h8000, 16'h7FFF, 16'h8100);
    wait_idle();
    do_start(16'h0000, 16'h1000, 16'h1000, 16'h0100, 16'h8000, 16'h7FFF, 16'h8100);
    wait_idle();

    // start and load_w together: load wins, no pass.
    @(negedge clk);
    w_init = {16'h0222, 16'h0111};
    b_init = 16'h0333;
    dZ     = 16'h0100;
    x      = {16'h0100, 16'h0100};
    lr     = 16'h0100;
    load_w = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    load_w = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    check("collide_w", w, 32'h0222_0111);
    check("collide_b", 32'(b), 32'h0333);
    check("collide_busy", 32'(busy), 32'h0);
    repeat (6) @(negedge clk);

    // Reset just before w1 would update.
    @(negedge clk);
    dZ    = 16'h0100;
    x     = {16'h0080, 16'h0200};
    lr    = 16'h0080;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("partial_w0", 32'(w[15:0]), 32'h0011);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_w", w, 32'h0);
    check("abort_b", 32'(b), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_start(16'h0100, 16'h0200, 16'h0080, 16'h0080, 16'hFF00, 16'hFFC0, 16'hFF80);
    wait_idle();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
